e203_exu_flush_arb: RTL and testbench
=====================================

# e203_exu_flush_arb

Parametrised pipeline-flush arbiter for the EXU commit stage. It merges NUM_SRC independent flush requesters into the single IFU flush handshake: exception/IRQ, branch-mispredict, debug, and future sources. Each requester supplies a flush-PC adder operand pair. The block selects one requester by fixed priority, locks the grant until the IFU acknowledges, and returns a per-source acknowledge. It also generates flush_pulse, the non-flush commit enable, and a completed-flush counter.

## Interface
Parameters:
- NUM_SRC, 3, number of flush requesters; index 0 has highest priority; legal range 2..8.
- PC_SIZE, 32, width of each flush adder operand.
- ID_W, 3, width of flush_src_id; must satisfy 2^ID_W ≥ NUM_SRC.
- CNT_W, 16, width of flush_cnt.

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, asynchronous active-low reset.
- src_req, input, NUM_SRC, per-source flush request; bit i belongs to source i.
- src_op1, input, NUM_SRC*PC_SIZE, per-source adder op1; source i occupies [i*PC_SIZE +: PC_SIZE].
- src_op2, input, NUM_SRC*PC_SIZE, per-source adder op2; same packing as src_op1.
- src_ack, output, NUM_SRC, one-hot0 acknowledge to the granted source.
- flush_req, output, 1, flush request to IFU.
- flush_op1, output, PC_SIZE, op1 of the granted source.
- flush_op2, output, PC_SIZE, op2 of the granted source.
- flush_ack, input, 1, IFU accepts the flush.
- flush_pulse, output, 1, flush_req & flush_ack.
- flush_src_id, output, ID_W, index of the granted source.
- cmt_ena, input, 1, raw commit enable.
- nonflush_cmt_ena, output, 1, cmt_ena & ~flush_req.
- cnt_clr, input, 1, synchronous clear of flush_cnt.
- flush_cnt, output, CNT_W, number of completed flushes.
- protocol_err, output, 1, sticky flag: a locked source dropped its request before ack.

## Operation
- States: IDLE and HOLD. lock_id (ID_W bits) holds the source index while in HOLD.
- Winner is the lowest index i with src_req[i]=1.
- Combinational mode (macro absent), IDLE:
  - With any request, flush_req=1 and ops/flush_src_id follow the winner.
  - With flush_ack in the same cycle: src_ack[winner]=1 and the state stays IDLE.
  - With no flush_ack: lock_id←winner and the state goes to HOLD.
- HOLD: flush_req=1 and ops come live from src[lock_id]. The grant stays with lock_id even if a higher-priority source asserts. flush_ack gives src_ack[lock_id]=1, and the next state is IDLE.
- A source must hold req and its ops stable until its src_ack. If src_req[lock_id] falls in HOLD without ack:
  - protocol_err←1.
  - Next state is IDLE, with no pulse and no src_ack.
  - flush_req deasserts in that same cycle.
- With no request, flush_ack is ignored: no pulse, no count.
- flush_cnt increments on each flush_pulse and wraps from 2^CNT_W−1 to 0. If cnt_clr and flush_pulse occur in the same cycle, clear wins and the count becomes 0.
- Ops and flush_src_id read 0 whenever flush_req=0.
- protocol_err clears only on reset.

## Timing
- Reset values: state IDLE, lock_id 0, flush_cnt 0, protocol_err 0. All outputs are 0, except nonflush_cmt_ena, which follows cmt_ena.
- Combinational mode: request-to-flush_req latency is 0 cycles, and src_ack follows flush_ack in the same cycle. The minimum flush occupancy is 1 cycle per source, so back-to-back flushes from different sources are possible on consecutive cycles.
- An asynchronous reset asserted mid-HOLD drops flush_req immediately, with no ack or pulse.

## Configuration
- Macro: E203_FLUSH_ARB_REG_OUT_EN.
- Defined: the output stage is registered.
  - IDLE with any request: at the clock edge, lock_id and the winner's op1/op2 are captured into registers, and the state goes to HOLD.
  - flush_req is asserted only in HOLD, with ops taken from the registers. This gives 1-cycle request latency.
  - No grant is issued from IDLE; flush_ack seen in IDLE is ignored.
  - HOLD behaves the same as in combinational mode, including the protocol_err rule.
  - After an acknowledged flush, at least one IDLE cycle separates consecutive flushes.
- Undefined: combinational behaviour as described above, with no operand registers.

## Test plan
- Single source: src_req=3'b010, op1=0x8000_0000, op2=0x4, flush_ack=1 in the same cycle. Required: flush_req=1, flush_op1=0x8000_0000, src_ack=3'b010, flush_pulse=1, flush_cnt=1.
- Priority with lock:
  - Source 2 requests, ack is withheld for 3 cycles, and source 0 asserts in cycle 1.
  - Required: flush_src_id stays 2 until ack. Source 0 is granted the following cycle.
  - flush_cnt=2 after the two flushes complete.
- Drop in HOLD: source 1 locked, then req falls without ack. Required: protocol_err=1 (sticky), flush_req=0, src_ack=0, flush_cnt unchanged.
- Counter: preload 0xFFFF flushes, then one more flush. Required: flush_cnt=0. Then cnt_clr together with a pulse. Required: flush_cnt=0.
- nonflush_cmt_ena: cmt_ena=1 with flush_req=1 gives 0; with flush_req=0 it gives 1.
- Registered mode (macro on): a request at cycle 0 gives flush_req=1 at cycle 1 with registered ops. Changing src_op1 at cycle 1 does not change flush_op1. Ack at cycle 2 gives src_ack at cycle 2 and IDLE at cycle 3.

Source files
------------

// File: rtl/e203_exu_flush_arb.sv
// Fixed-priority flush arbiter: merges NUM_SRC flush requesters into one IFU flush handshake.
// Latency: 0 cycles request-to-flush_req by default; 1 cycle with E203_FLUSH_ARB_REG_OUT_EN defined.
// Backpressure: the grant is locked to one source until flush_ack; other requesters wait.
module e203_exu_flush_arb #(
  parameter int NUM_SRC = 3,
  parameter int PC_SIZE = 32,
  parameter int ID_W    = 3,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_req_i,
  input  logic [NUM_SRC*PC_SIZE-1:0] src_op1_i,
  input  logic [NUM_SRC*PC_SIZE-1:0] src_op2_i,
  output logic [NUM_SRC-1:0]         src_ack_o,
  output logic                       flush_req_o,
  output logic [PC_SIZE-1:0]         flush_op1_o,
  output logic [PC_SIZE-1:0]         flush_op2_o,
  input  logic                       flush_ack_i,
  output logic                       flush_pulse_o,
  output logic [ID_W-1:0]            flush_src_id_o,
  input  logic                       cmt_ena_i,
  output logic                       nonflush_cmt_ena_o,
  input  logic                       cnt_clr_i,
  output logic [CNT_W-1:0]           flush_cnt_o,
  output logic                       protocol_err_o
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    lock_id_q, lock_id_d;
  logic               protocol_err_q, protocol_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               any_req;
  logic [ID_W-1:0]    win_id;
  logic               lock_req;
  logic               grant;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    mux_id;
  logic [PC_SIZE-1:0] mux_op1, mux_op2;
  logic [PC_SIZE-1:0] out_op1, out_op2;

  // Priority encode: lowest requesting index wins.
  always_comb begin
    any_req = |src_req_i;
    win_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_req_i[i]) win_id = ID_W'(i);
    end
  end

  // Live request level of the locked source.
  always_comb begin
    lock_req = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (lock_id_q == ID_W'(i)) lock_req = src_req_i[i];
    end
  end

  // Next-state and grant decode.
  always_comb begin
    state_d        = state_q;
    lock_id_d      = lock_id_q;
    protocol_err_d = protocol_err_q;
    grant          = 1'b0;
    sel_id         = '0;
    case (state_q)
      IDLE: begin
`ifdef E203_FLUSH_ARB_REG_OUT_EN
        // Registered output stage: capture the winner, grant next cycle.
        if (any_req) begin
          state_d   = HOLD;
          lock_id_d = win_id;
        end
`else
        // Grant straight away; only lock if the IFU stalls.
        if (any_req) begin
          grant  = 1'b1;
          sel_id = win_id;
          if (!flush_ack_i) begin
            state_d   = HOLD;
            lock_id_d = win_id;
          end
        end
`endif
      end
      HOLD: begin
        if (lock_req) begin
          grant  = 1'b1;
          sel_id = lock_id_q;
          if (flush_ack_i) state_d = IDLE;
        end else begin
          // Locked source abandoned its flush: flag it and release the grant.
          protocol_err_d = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef E203_FLUSH_ARB_REG_OUT_EN
  assign mux_id = win_id;
`else
  assign mux_id = sel_id;
`endif

  // Operand mux: granted source (combinational) or winner to capture (registered).
  always_comb begin
    mux_op1 = '0;
    mux_op2 = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mux_id == ID_W'(i)) begin
        mux_op1 = src_op1_i[i*PC_SIZE +: PC_SIZE];
        mux_op2 = src_op2_i[i*PC_SIZE +: PC_SIZE];
      end
    end
  end

`ifdef E203_FLUSH_ARB_REG_OUT_EN
  logic [PC_SIZE-1:0] op1_q, op2_q;

  // Operand capture when leaving IDLE; held stable for the whole HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      op1_q <= mux_op1;
      op2_q <= mux_op2;
    end
  end

  assign out_op1 = op1_q;
  assign out_op2 = op2_q;
`else
  assign out_op1 = mux_op1;
  assign out_op2 = mux_op2;
`endif

  // Outputs are quiet while reset is held, so a mid-flush reset drops the request at once.
  assign flush_req_o        = grant & rst_n;
  assign flush_pulse_o      = flush_req_o & flush_ack_i;
  assign flush_op1_o        = flush_req_o ? out_op1 : '0;
  assign flush_op2_o        = flush_req_o ? out_op2 : '0;
  assign flush_src_id_o     = flush_req_o ? sel_id : '0;
  assign nonflush_cmt_ena_o = cmt_ena_i & ~flush_req_o;
  assign flush_cnt_o        = cnt_q;
  assign protocol_err_o     = protocol_err_q;

  // One-hot acknowledge back to the granted source.
  always_comb begin
    src_ack_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ack_o[i] = flush_pulse_o && (sel_id == ID_W'(i));
    end
  end

  // Completed-flush counter; clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)          cnt_d = '0;
    else if (flush_pulse_o) cnt_d = cnt_q + 1'b1;
  end

  // State, lock and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lock_id_q      <= '0;
      protocol_err_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      lock_id_q      <= lock_id_d;
      protocol_err_q <= protocol_err_d;
      cnt_q          <= cnt_d;
    end
  end

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
module tb_e203_exu_flush_arb;
  localparam int N  = 3;
  localparam int PW = 32;
  localparam int IW = 3;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_req = '0;
  logic [N*PW-1:0] src_op1 = '0;
  logic [N*PW-1:0] src_op2 = '0;
  logic            flush_ack = 1'b0;
  logic            cmt_ena = 1'b0;
  logic            cnt_clr = 1'b0;

  logic [N-1:0]    src_ack;
  logic            flush_req;
  logic [PW-1:0]   flush_op1, flush_op2;
  logic            flush_pulse;
  logic [IW-1:0]   flush_src_id;
  logic            nonflush_cmt_ena;
  logic [CW-1:0]   flush_cnt;
  logic            protocol_err;

  always #5 clk = ~clk;

  e203_exu_flush_arb #(.NUM_SRC(N), .PC_SIZE(PW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_req_i(src_req), .src_op1_i(src_op1), .src_op2_i(src_op2),
    .src_ack_o(src_ack), .flush_req_o(flush_req),
    .flush_op1_o(flush_op1), .flush_op2_o(flush_op2),
    .flush_ack_i(flush_ack), .flush_pulse_o(flush_pulse),
    .flush_src_id_o(flush_src_id), .cmt_ena_i(cmt_ena),
    .nonflush_cmt_ena_o(nonflush_cmt_ena), .cnt_clr_i(cnt_clr),
    .flush_cnt_o(flush_cnt), .protocol_err_o(protocol_err)
  );

  int passes = 0;
  int checks = 0;

  typedef struct {
    string       n;
    logic [63:0] a;
    logic [63:0] e;
  } lit_t;
  lit_t litq[$];

  // Behavioural model: who owns the IFU (-1 = nobody), sticky error, flush count.
  int          m_lock = -1;
  bit          m_err  = 1'b0;
  int unsigned m_cnt  = 0;
  logic [PW-1:0] m_op1_r = '0, m_op2_r = '0;
  int          win;
  logic        e_fr, e_pulse;
  int          e_id;
  logic [PW-1:0] e_op1, e_op2;
  logic [N-1:0]  e_ack;

  always_comb begin
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (src_req[i]) win = i;
    e_fr = 1'b0; e_id = 0; e_op1 = '0; e_op2 = '0; e_ack = '0; e_pulse = 1'b0;
    if (rst_n) begin
      if (m_lock >= 0) begin
        if (src_req[m_lock]) begin e_fr = 1'b1; e_id = m_lock; end
      end
`ifndef E203_FLUSH_ARB_REG_OUT_EN
      else if (win >= 0) begin e_fr = 1'b1; e_id = win; end
`endif
    end
    if (e_fr) begin
`ifdef E203_FLUSH_ARB_REG_OUT_EN
      e_op1 = m_op1_r; e_op2 = m_op2_r;
`else
      e_op1 = src_op1[e_id*PW +: PW]; e_op2 = src_op2[e_id*PW +: PW];
`endif
      e_pulse = flush_ack;
      if (flush_ack) e_ack[e_id] = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lock <= -1; m_err <= 1'b0; m_cnt <= 0;
    end else begin
      if (cnt_clr) m_cnt <= 0;
      else if (e_fr && flush_ack) m_cnt <= (m_cnt + 1) % 65536;
      if (m_lock >= 0) begin
        if (!src_req[m_lock]) begin m_err <= 1'b1; m_lock <= -1; end
        else if (flush_ack) m_lock <= -1;
      end else if (win >= 0) begin
`ifdef E203_FLUSH_ARB_REG_OUT_EN
        m_lock  <= win;
        m_op1_r <= src_op1[win*PW +: PW];
        m_op2_r <= src_op2[win*PW +: PW];
`else
        if (!flush_ack) m_lock <= win;
`endif
      end
    end
  end

  // Single compare process: model check every cycle plus queued literal checks.
  logic [89:0] act_v, exp_v;
  always @(negedge clk) begin
    act_v = {flush_req, flush_src_id, src_ack, flush_pulse, nonflush_cmt_ena,
             protocol_err, flush_cnt, flush_op1, flush_op2};
    exp_v = {e_fr, IW'(e_id), e_ack, e_pulse, cmt_ena & ~e_fr,
             m_err, CW'(m_cnt), e_op1, e_op2};
    checks++;
    if (act_v === exp_v) passes++;
    else $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act_v, exp_v);
    while (litq.size() > 0) begin
      lit_t l;
      l = litq.pop_front();
      checks++;
      if (l.a === l.e) passes++;
      else $display("FAIL %s t=%0t got=%h want=%h", l.n, $time, l.a, l.e);
    end
  end

  task automatic lit(input string n, input logic [63:0] a, input logic [63:0] e);
    lit_t l;
    l.n = n; l.a = a; l.e = e;
    litq.push_back(l);
  endtask

  task automatic set_ops(input int i, input logic [PW-1:0] o1, input logic [PW-1:0] o2);
    src_op1[i*PW +: PW] = o1;
    src_op2[i*PW +: PW] = o2;
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic a, input logic clr);
    src_req = r; flush_ack = a; cnt_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmt_ena = 1'b1;
    step();
    #3;
    lit("rst_flush_req", 64'(flush_req), 64'h0);
    lit("rst_nonflush", 64'(nonflush_cmt_ena), 64'h1);
    lit("rst_cnt", 64'(flush_cnt), 64'h0);
    lit("rst_err", 64'(protocol_err), 64'h0);
    step();
    rst_n = 1'b1;
    step();
`ifndef E203_FLUSH_ARB_REG_OUT_EN
    // Single source with same-cycle ack.
    set_ops(1, 32'h8000_0000, 32'h4);
    cyc(3'b010, 1'b1, 1'b0); #3;
    lit("single_req", 64'(flush_req), 64'h1);
    lit("single_op1", 64'(flush_op1), 64'h8000_0000);
    lit("single_op2", 64'(flush_op2), 64'h4);
    lit("single_ack", 64'(src_ack), 64'h2);
    lit("single_pulse", 64'(flush_pulse), 64'h1);
    lit("single_nonflush", 64'(nonflush_cmt_ena), 64'h0);
    step();
    lit("single_cnt", 64'(flush_cnt), 64'h1);
    // Priority with lock: source 2 held while source 0 asserts.
    cyc(3'b000, 1'b0, 1'b1); step();
    set_ops(2, 32'h0000_2000, 32'h10);
    set_ops(0, 32'h0000_0100, 32'h20);
    cyc(3'b100, 1'b0, 1'b0); #3; lit("lock_id_c0", 64'(flush_src_id), 64'h2); step();
    cyc(3'b101, 1'b0, 1'b0); #3; lit("lock_id_c1", 64'(flush_src_id), 64'h2); step();
    cyc(3'b101, 1'b0, 1'b0); #3; lit("lock_op1_c2", 64'(flush_op1), 64'h2000); step();
    cyc(3'b101, 1'b1, 1'b0); #3; lit("lock_ack_c3", 64'(src_ack), 64'h4); step();
    cyc(3'b001, 1'b1, 1'b0); #3; lit("next_id", 64'(flush_src_id), 64'h0);
    lit("next_ack", 64'(src_ack), 64'h1); step();
    lit("lock_cnt", 64'(flush_cnt), 64'h2);
    // Locked source drops its request.
    cyc(3'b010, 1'b0, 1'b0); step();
    cyc(3'b000, 1'b0, 1'b0); #3;
    lit("drop_req", 64'(flush_req), 64'h0);
    lit("drop_ack", 64'(src_ack), 64'h0);
    step();
    lit("drop_err", 64'(protocol_err), 64'h1);
    lit("drop_cnt", 64'(flush_cnt), 64'h2);
    cyc(3'b001, 1'b1, 1'b0); step();
    lit("err_sticky", 64'(protocol_err), 64'h1);
    // nonflush commit enable.
    cyc(3'b010, 1'b0, 1'b0); #3; lit("nfc_busy", 64'(nonflush_cmt_ena), 64'h0); step();
    cyc(3'b010, 1'b1, 1'b0); step();
    cyc(3'b000, 1'b0, 1'b0); #3; lit("nfc_idle", 64'(nonflush_cmt_ena), 64'h1); step();
    // Ack with no request is ignored.
    cyc(3'b000, 1'b1, 1'b0); #3; lit("idle_ack_pulse", 64'(flush_pulse), 64'h0); step();
    lit("idle_ack_cnt", 64'(flush_cnt), 64'h4);
    // Back-to-back flushes from different sources.
    cyc(3'b011, 1'b1, 1'b0); #3; lit("b2b_id0", 64'(flush_src_id), 64'h0); step();
    cyc(3'b010, 1'b1, 1'b0); #3; lit("b2b_ack1", 64'(src_ack), 64'h2); step();
    lit("b2b_cnt", 64'(flush_cnt), 64'h6);
    // Counter wrap and clear-beats-pulse.
    cyc(3'b000, 1'b0, 1'b1); step();
    for (int k = 0; k < 65535; k++) begin
      cyc(3'b001, 1'b1, 1'b0); step();
    end
    lit("cnt_full", 64'(flush_cnt), 64'hFFFF);
    cyc(3'b001, 1'b1, 1'b0); step();
    lit("cnt_wrap", 64'(flush_cnt), 64'h0);
    cyc(3'b001, 1'b1, 1'b0); step();
    cyc(3'b001, 1'b1, 1'b1); #3; lit("clr_pulse", 64'(flush_pulse), 64'h1); step();
    lit("clr_wins", 64'(flush_cnt), 64'h0);
`else
    // Registered output stage: one cycle latency, operands frozen.
    set_ops(1, 32'h0000_0100, 32'h8);
    cyc(3'b010, 1'b0, 1'b0); #3; lit("reg_c0_req", 64'(flush_req), 64'h0); step();
    set_ops(1, 32'h0000_0200, 32'h8); #3;
    lit("reg_c1_req", 64'(flush_req), 64'h1);
    lit("reg_c1_op1", 64'(flush_op1), 64'h100);
    lit("reg_c1_id", 64'(flush_src_id), 64'h1);
    step();
    cyc(3'b010, 1'b1, 1'b0); #3;
    lit("reg_c2_ack", 64'(src_ack), 64'h2);
    lit("reg_c2_pulse", 64'(flush_pulse), 64'h1);
    step();
    cyc(3'b000, 1'b0, 1'b0); #3; lit("reg_c3_idle", 64'(flush_req), 64'h0); step();
    lit("reg_cnt", 64'(flush_cnt), 64'h1);
    cyc(3'b000, 1'b1, 1'b0); #3; lit("reg_idle_ack", 64'(src_ack), 64'h0); step();
    cyc(3'b001, 1'b0, 1'b0); step();
    cyc(3'b000, 1'b0, 1'b0); #3; lit("reg_drop_req", 64'(flush_req), 64'h0); step();
    lit("reg_drop_err", 64'(protocol_err), 64'h1);
    lit("reg_drop_cnt", 64'(flush_cnt), 64'h1);
    cyc(3'b100, 1'b0, 1'b0); step();
`endif
    // Asynchronous reset in the middle of a held flush.
    cyc(3'b100, 1'b0, 1'b0); step();
    #1; lit("pre_rst_req", 64'(flush_req), 64'h1);
    rst_n = 1'b0; #1;
    lit("arst_req", 64'(flush_req), 64'h0);
    lit("arst_ack", 64'(src_ack), 64'h0);
    lit("arst_err", 64'(protocol_err), 64'h0);
    step();
    rst_n = 1'b1;
    cyc(3'b000, 1'b0, 1'b0);
    step(); step();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
